// File: rtl/sync_cnt_pkg.sv
// Shared types and the next-state step function for the synchronous modulo-N counter.
// Used by sync_mod_counter_divider; widths up to CNT_MAX_W-1 bits are supported.
package sync_cnt_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int unsigned CNT_MAX_W = 32;

  typedef struct packed {
    logic                 wrap;
    logic [CNT_MAX_W-1:0] next;
  } step_t;

  // One enabled step of a modulo-'modulus' counter; 'wrap' flags the edge that
  // crosses the sequence boundary in either direction.
  function automatic step_t next_count(input logic [CNT_MAX_W-1:0] cur,
                                       input dir_e                 dir,
                                       input logic [CNT_MAX_W-1:0] modulus);
    step_t s;
    s.wrap = 1'b0;
    s.next = cur;
    if (dir == DIR_UP) begin
      if (cur == modulus - 32'd1) begin
        s.wrap = 1'b1;
        s.next = '0;
      end else begin
        s.next = cur + 32'd1;
      end
    end else begin
      if (cur == '0) begin
        s.wrap = 1'b1;
        s.next = modulus - 32'd1;
      end else begin
        s.next = cur - 32'd1;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/sync_mod_counter_divider.sv
// Fully synchronous modulo-N up/down counter with terminal-count strobe and 50% divided output.
// Optional parallel load is compiled in when SYNC_CNT_LOAD_EN is defined.
module sync_mod_counter_divider
  import sync_cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  dir_e             dir,
`ifdef SYNC_CNT_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             div_out
);

  if (WIDTH < 1 || WIDTH >= CNT_MAX_W) begin : g_bad_width
    $error("sync_mod_counter_divider: WIDTH=%0d out of range 1..%0d", WIDTH, CNT_MAX_W - 1);
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("sync_mod_counter_divider: MODULUS=%0d out of range 2..2**WIDTH", MODULUS);
  end

  localparam logic [CNT_MAX_W-1:0] MOD_EXT = CNT_MAX_W'(MODULUS);
  localparam logic [WIDTH-1:0]     MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             div_q, div_d;

  logic             load_sel;
  logic [WIDTH-1:0] load_clamped;
  step_t            step_s;
  logic             unused_step_hi;

`ifdef SYNC_CNT_LOAD_EN
  assign load_sel     = load;
  assign load_clamped = (CNT_MAX_W'(load_val) >= MOD_EXT) ? MAX_VAL : load_val;
`else
  assign load_sel     = 1'b0;
  assign load_clamped = '0;
`endif

  assign step_s         = next_count(CNT_MAX_W'(count_q), dir, MOD_EXT);
  assign unused_step_hi = ^step_s.next[CNT_MAX_W-1:WIDTH];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    tc_d    = 1'b0;
    div_d   = div_q;
    if (load_sel) begin
      count_d = load_clamped;
    end else if (en) begin
      count_d = step_s.next[WIDTH-1:0];
      tc_d    = step_s.wrap;
      div_d   = div_q ^ step_s.wrap;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      div_q   <= div_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign div_out = div_q;

endmodule

// File: tb/tb_sync_mod_counter_divider.sv
// Directed bench for sync_mod_counter_divider: WIDTH=4/MODULUS=10 main instance plus a WIDTH=1/MODULUS=2 instance.
// Load checks are included when SYNC_CNT_LOAD_EN is defined.
module tb_sync_mod_counter_divider;
  import sync_cnt_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en;
  dir_e       dir;
  logic [3:0] count;
  logic       tc, div_out;

  logic       rst2, en2;
  dir_e       dir2;
  logic [0:0] count2;
  logic       tc2, div_out2;

`ifdef SYNC_CNT_LOAD_EN
  logic       load, load2;
  logic [3:0] load_val;
  logic [0:0] load_val2;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sync_mod_counter_divider #(.WIDTH(4), .MODULUS(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .dir     (dir),
`ifdef SYNC_CNT_LOAD_EN
    .load    (load),
    .load_val(load_val),
`endif
    .count   (count),
    .tc      (tc),
    .div_out (div_out)
  );

  sync_mod_counter_divider #(.WIDTH(1), .MODULUS(2)) dut2 (
    .clk     (clk),
    .rst     (rst2),
    .en      (en2),
    .dir     (dir2),
`ifdef SYNC_CNT_LOAD_EN
    .load    (load2),
    .load_val(load_val2),
`endif
    .count   (count2),
    .tc      (tc2),
    .div_out (div_out2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_main(input string tag, input int c, input int t, input int d);
    check({tag, ".count"}, 32'(count), c);
    check({tag, ".tc"}, 32'(tc), t);
    check({tag, ".div_out"}, 32'(div_out), d);
  endtask

  task automatic check_m2(input string tag, input int c, input int t, input int d);
    check({tag, ".count"}, 32'(count2), c);
    check({tag, ".tc"}, 32'(tc2), t);
    check({tag, ".div_out"}, 32'(div_out2), d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst  = 1'b1; en  = 1'b0; dir  = DIR_UP;
    rst2 = 1'b1; en2 = 1'b0; dir2 = DIR_UP;
`ifdef SYNC_CNT_LOAD_EN
    load = 1'b0; load_val = '0; load2 = 1'b0; load_val2 = '0;
`endif

    // Reset held for three cycles
    repeat (3) step();
    check_main("reset", 0, 0, 0);

    // Up count for 25 enabled edges: wrap every 10, div_out flips on each wrap
    rst = 1'b0; en = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      step();
      check_main("up_run", i % 10, int'(i % 10 == 0), (i / 10) % 2);
    end

    // Hold at 5 with en low
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_main("hold", 5, 0, 0);
    end
    en = 1'b1;
    step();
    check_main("resume", 6, 0, 0);

    // Reach 9, flip to down at the boundary: no wrap
    repeat (3) step();
    check_main("up_to_9", 9, 0, 0);
    dir = DIR_DOWN;
    step();
    check_main("flip_down_at_9", 8, 0, 0);
    for (int i = 7; i >= 0; i--) begin
      step();
      check_main("down_run", i, 0, 0);
    end
    step();
    check_main("down_wrap", 9, 1, 1);
    dir = DIR_UP;
    step();
    check_main("up_wrap_after_down", 0, 1, 0);

    // Bring div_out high and count to 7, then reset mid-sequence
    repeat (10) step();
    check_main("wrap_to_div1", 0, 1, 1);
    repeat (7) step();
    check_main("at_7", 7, 0, 1);
    rst = 1'b1;
    step();
    check_main("rst_mid", 0, 0, 0);

    // Down from reset: immediate wrap to 9
    rst = 1'b0; dir = DIR_DOWN;
    step();
    check_main("down_from_reset", 9, 1, 1);
    en = 1'b0;
    step();
    check_main("hold_after_wrap", 9, 0, 1);
    en = 1'b1;
    step();
    check_main("down_8", 8, 0, 1);
    step();
    check_main("down_7", 7, 0, 1);

`ifdef SYNC_CNT_LOAD_EN
    // Out-of-range load clamps to 9; load beats en and never strobes tc
    load = 1'b1; load_val = 4'd12;
    step();
    check_main("load_clamp", 9, 0, 1);
    load = 1'b0; dir = DIR_UP;
    step();
    check_main("wrap_after_load", 0, 1, 0);
    load = 1'b1; load_val = 4'd3; en = 1'b0;
    step();
    check_main("load_3", 3, 0, 0);
    load_val = 4'd9; en = 1'b1;
    step();
    check_main("load_9", 9, 0, 0);
    load = 1'b0;
    step();
    check_main("wrap_from_loaded_9", 0, 1, 1);
`endif

    // MODULUS == 2**WIDTH == 2: wrap every other edge, div_out toggles every 2 cycles
    step();
    check_m2("m2_reset", 0, 0, 0);
    rst2 = 1'b0; en2 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      check_m2("m2_up", i % 2, int'(i % 2 == 0), (i / 2) % 2);
    end
    dir2 = DIR_DOWN;
    step();
    check_m2("m2_down_wrap", 1, 1, 0);
    step();
    check_m2("m2_down_step", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
